// File: rtl/cmd_frame_master_pkg.sv
// cmd_frame_pkg: command-protocol opcodes, frame/reply lengths and frame byte builder.
// Shared with the system controller so both ends agree on opcodes.
package cmd_frame_pkg;

    typedef enum logic [1:0] {CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOOP} cmd_e;

    localparam logic [7:0] OPC_RF_WR    = 8'hAA;
    localparam logic [7:0] OPC_RF_RD    = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP   = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOOP = 8'hDD;

    function automatic logic [7:0] opcode(cmd_e c);
        return (c == CMD_RF_WR) ? OPC_RF_WR : (c == CMD_RF_RD) ? OPC_RF_RD :
               (c == CMD_ALU_OP) ? OPC_ALU_OP : OPC_ALU_NOOP;
    endfunction

    function automatic logic [2:0] frame_len(cmd_e c);
        return (c == CMD_RF_WR) ? 3'd3 : (c == CMD_ALU_OP) ? 3'd4 : 3'd2;
    endfunction

    function automatic logic [1:0] reply_len(cmd_e c);
        return (c == CMD_RF_WR) ? 2'd0 : (c == CMD_RF_RD) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [7:0] frame_byte(cmd_e c, logic [1:0] idx, logic [3:0] addr,
                                              logic [7:0] wr_data, logic [7:0] op_a,
                                              logic [7:0] op_b, logic [3:0] fun);
        logic [7:0] arg;
        case (c)
            CMD_RF_WR:  arg = (idx == 2'd1) ? {4'h0, addr} : wr_data;
            CMD_RF_RD:  arg = {4'h0, addr};
            CMD_ALU_OP: arg = (idx == 2'd1) ? op_a : (idx == 2'd2) ? op_b : {4'h0, fun};
            default:    arg = {4'h0, fun};
        endcase
        return (idx == 2'd0) ? opcode(c) : arg;
    endfunction

endpackage

// File: rtl/cmd_frame_master_rsp_timer.sv
// rsp_timer: reply-gap timer; counts run cycles since the last load, saturating at the limit.
module rsp_timer #(
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_arst_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam logic [TIMEOUT_W-1:0] LP_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [TIMEOUT_W-1:0] r_cnt;

    assign o_expired = (r_cnt == LP_LIMIT);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= '0;
        else if (i_run && !o_expired)
            r_cnt <= r_cnt + TIMEOUT_W'(1);
    end

endmodule

// File: rtl/cmd_frame_master.sv
// cmd_frame_master: serializes one command into an AA/BB/CC/DD byte frame toward UART TX
// and gathers the 0/1/2-byte reply from UART RX into a single response, with timeout.
module cmd_frame_master #(
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_type,
    input  logic [3:0]  i_addr,
    input  logic [7:0]  i_wr_data,
    input  logic [7:0]  i_op_a,
    input  logic [7:0]  i_op_b,
    input  logic [3:0]  i_alu_fun,
    output logic [7:0]  o_tx_p_data,
    output logic        o_tx_p_valid,
    input  logic        i_tx_ready,
    input  logic        i_rx_d_valid,
    input  logic [7:0]  i_rx_p_data,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_data,
    output logic        o_rsp_timeout,
    output logic        o_rx_drop
);

    import cmd_frame_pkg::*;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RSP, S_DONE} state_e;

    state_e      r_state;
    cmd_e        r_cmd;
    logic [3:0]  r_addr;
    logic [3:0]  r_fun;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_op_a;
    logic [7:0]  r_op_b;
    logic [1:0]  r_byte_idx;
    logic        r_rx_idx;
    logic [15:0] r_rsp_buf;
    logic        r_cmd_ready;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_data;
    logic        r_rsp_timeout;
    logic        r_rx_drop;

    logic        w_tx_last;
    logic        w_rx_last;
    logic        w_timer_load;
    logic        w_expired;
    logic [7:0]  w_next_byte;
    logic [15:0] w_rsp_merged;

    assign w_tx_last    = ({1'b0, r_byte_idx} == frame_len(r_cmd) - 3'd1);
    assign w_rx_last    = ({1'b0, r_rx_idx} == reply_len(r_cmd) - 2'd1);
    assign w_next_byte  = frame_byte(r_cmd, r_byte_idx + 2'd1, r_addr, r_wr_data, r_op_a, r_op_b, r_fun);
    // Low reply byte arrives first; the buffer is cleared on accept so partial replies read as {00,lo}.
    assign w_rsp_merged = r_rx_idx ? {i_rx_p_data, r_rsp_buf[7:0]} : {8'h00, i_rx_p_data};
    assign w_timer_load = (r_state == S_SEND && i_tx_ready && w_tx_last) ||
                          (r_state == S_WAIT_RSP && i_rx_d_valid);

    rsp_timer #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rsp_timer (
        .i_clk     (i_clk),
        .i_arst_n  (i_arst_n),
        .i_load    (w_timer_load),
        .i_run     (r_state == S_WAIT_RSP),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state       <= S_IDLE;
            r_cmd         <= CMD_RF_WR;
            r_addr        <= '0;
            r_fun         <= '0;
            r_wr_data     <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_byte_idx    <= '0;
            r_rx_idx      <= 1'b0;
            r_rsp_buf     <= '0;
            r_cmd_ready   <= 1'b1;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_rx_drop     <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rx_drop   <= i_rx_d_valid && (r_state != S_WAIT_RSP);
            case (r_state)
                S_IDLE: if (i_cmd_valid) begin
                    r_cmd       <= cmd_e'(i_cmd_type);
                    r_addr      <= i_addr;
                    r_fun       <= i_alu_fun;
                    r_wr_data   <= i_wr_data;
                    r_op_a      <= i_op_a;
                    r_op_b      <= i_op_b;
                    r_byte_idx  <= '0;
                    r_rx_idx    <= 1'b0;
                    r_rsp_buf   <= '0;
                    r_cmd_ready <= 1'b0;
                    r_tx_valid  <= 1'b1;
                    r_tx_data   <= opcode(cmd_e'(i_cmd_type));
                    r_state     <= S_SEND;
                end
                S_SEND: if (i_tx_ready) begin
                    if (w_tx_last) begin
                        r_tx_valid <= 1'b0;
                        if (reply_len(r_cmd) == 2'd0) begin
                            r_state       <= S_DONE;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_data    <= r_rsp_buf;
                            r_rsp_timeout <= 1'b0;
                        end else begin
                            r_state <= S_WAIT_RSP;
                        end
                    end else begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_tx_data  <= w_next_byte;
                    end
                end
                // A byte landing on the expiry cycle wins over the timeout.
                S_WAIT_RSP: if (i_rx_d_valid) begin
                    r_rsp_buf <= w_rsp_merged;
                    r_rx_idx  <= 1'b1;
                    if (w_rx_last) begin
                        r_state       <= S_DONE;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_data    <= w_rsp_merged;
                        r_rsp_timeout <= 1'b0;
                    end
                end else if (w_expired) begin
                    r_state       <= S_DONE;
                    r_rsp_valid   <= 1'b1;
                    r_rsp_data    <= r_rsp_buf;
                    r_rsp_timeout <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_tx_p_valid  = r_tx_valid;
    assign o_tx_p_data   = r_tx_data;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_rx_drop     = r_rx_drop;

endmodule

// File: tb/tb_cmd_frame_master.sv
// tb_cmd_frame_master: table-driven and randomized checks of cmd_frame_master
// against a byte-level model of the command protocol.
module tb_cmd_frame_master;

    localparam int T = 24;

    logic        clk = 1'b0;
    logic        i_arst_n = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_type = '0;
    logic [3:0]  i_addr = '0;
    logic [7:0]  i_wr_data = '0;
    logic [7:0]  i_op_a = '0;
    logic [7:0]  i_op_b = '0;
    logic [3:0]  i_alu_fun = '0;
    logic [7:0]  o_tx_p_data;
    logic        o_tx_p_valid;
    logic        i_tx_ready = 1'b0;
    logic        i_rx_d_valid = 1'b0;
    logic [7:0]  i_rx_p_data = '0;
    logic        o_rsp_valid;
    logic [15:0] o_rsp_data;
    logic        o_rsp_timeout;
    logic        o_rx_drop;

    cmd_frame_master #(.TIMEOUT_W(16), .TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_arst_n(i_arst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_type(i_cmd_type), .i_addr(i_addr), .i_wr_data(i_wr_data), .i_op_a(i_op_a),
        .i_op_b(i_op_b), .i_alu_fun(i_alu_fun), .o_tx_p_data(o_tx_p_data),
        .o_tx_p_valid(o_tx_p_valid), .i_tx_ready(i_tx_ready), .i_rx_d_valid(i_rx_d_valid),
        .i_rx_p_data(i_rx_p_data), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_rsp_timeout(o_rsp_timeout), .o_rx_drop(o_rx_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cmd;
        logic [3:0]  addr;
        logic [7:0]  wd, a, b;
        logic [3:0]  fun;
        int          nrep;
        logic [7:0]  r0, r1;
        int          mode;
        int          late;
        int          len;
        logic [31:0] tx;
        logic [15:0] rsp;
        logic        to;
    } vec_t;

    int pass_cnt = 0;
    int total = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    logic [7:0] got_tx[$];
    vec_t vt[8];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (o_rsp_valid) rsp_cnt <= rsp_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic vec_t mk(logic [1:0] cmd, logic [3:0] addr, logic [7:0] wd, logic [7:0] a,
                                logic [7:0] b, logic [3:0] fun, int nrep, logic [7:0] r0,
                                logic [7:0] r1, int mode, int late, int len, logic [31:0] tx,
                                logic [15:0] rsp, logic to);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.wd = wd; v.a = a; v.b = b; v.fun = fun;
        v.nrep = nrep; v.r0 = r0; v.r1 = r1; v.mode = mode; v.late = late;
        v.len = len; v.tx = tx; v.rsp = rsp; v.to = to;
        return v;
    endfunction

    // Protocol model: opcode is AA + 11*type; frame lengths 3/2/4/2; replies 0/1/2/2, low byte first.
    function automatic vec_t model(logic [1:0] cmd, logic [3:0] addr, logic [7:0] wd, logic [7:0] a,
                                   logic [7:0] b, logic [3:0] fun, int nrep, logic [7:0] r0,
                                   logic [7:0] r1, int mode);
        int lens[4] = '{3, 2, 4, 2};
        int rls[4]  = '{0, 1, 2, 2};
        logic [7:0] op = 8'hAA + 8'h11 * 8'(cmd);
        logic [31:0] tx;
        int n;
        logic [15:0] rsp;
        case (cmd)
            2'd0:    tx = {op, 4'h0, addr, wd, 8'h00};
            2'd1:    tx = {op, 4'h0, addr, 16'h0000};
            2'd2:    tx = {op, a, b, 4'h0, fun};
            default: tx = {op, 4'h0, fun, 16'h0000};
        endcase
        n = (nrep < rls[cmd]) ? nrep : rls[cmd];
        rsp = (n == 0) ? 16'h0000 : (n == 1) ? {8'h00, r0} : {r1, r0};
        return mk(cmd, addr, wd, a, b, fun, nrep, r0, r1, mode, 0, lens[cmd], tx, rsp,
                  nrep < rls[cmd]);
    endfunction

    task automatic run_cmd(input vec_t v);
        int g, c0, ref_cyc;
        logic rdy, hold;
        logic [7:0] prev, rb;
        got_tx.delete();
        @(negedge clk);
        chk("ready_idle", o_cmd_ready, 1);
        i_cmd_valid = 1; i_cmd_type = v.cmd; i_addr = v.addr; i_wr_data = v.wd;
        i_op_a = v.a; i_op_b = v.b; i_alu_fun = v.fun;
        @(negedge clk);
        i_cmd_valid = 0;
        chk("ready_busy", o_cmd_ready, 0);
        chk("tx_valid_first", o_tx_p_valid, 1);
        c0 = rsp_cnt;
        g = 0; hold = 0; prev = '0;
        while (got_tx.size() < v.len && g < 200) begin
            if (hold) begin
                chk("tx_hold_valid", o_tx_p_valid, 1);
                chk("tx_hold_data", o_tx_p_data, prev);
            end
            rdy = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? g[0] : 1'($urandom_range(0, 1));
            i_tx_ready = rdy;
            i_cmd_valid = (g == 0);
            if (g == 0) begin i_op_a = ~v.a; i_addr = ~v.addr; i_cmd_type = ~v.cmd; end
            if (o_tx_p_valid && rdy) got_tx.push_back(o_tx_p_data);
            hold = o_tx_p_valid && !rdy;
            prev = o_tx_p_data;
            @(negedge clk);
            i_cmd_valid = 0;
            g++;
        end
        i_tx_ready = 0;
        ref_cyc = cyc;
        chk("tx_count", got_tx.size(), v.len);
        if (v.mode == 0) chk("tx_back2back", g, v.len);
        for (int k = 0; k < got_tx.size() && k < 4; k++) begin
            rb = v.tx[31 - 8 * k -: 8];
            chk($sformatf("tx_byte%0d", k), got_tx[k], rb);
        end
        chk("tx_valid_after", o_tx_p_valid, 0);
        for (int k = 0; k < v.nrep; k++) begin
            if (v.late != 0 && k == 0) while (cyc < ref_cyc + T) @(negedge clk);
            else repeat ($urandom_range(0, 3)) @(negedge clk);
            i_rx_d_valid = 1; i_rx_p_data = (k == 0) ? v.r0 : v.r1;
            @(negedge clk);
            i_rx_d_valid = 0;
            ref_cyc = cyc;
        end
        g = 0;
        while (!o_rsp_valid && g < 4 * T + 50) begin @(negedge clk); g++; end
        chk("rsp_seen", o_rsp_valid, 1);
        if (o_rsp_valid) begin
            chk("rsp_data", o_rsp_data, v.rsp);
            chk("rsp_timeout", o_rsp_timeout, v.to);
            if (v.to) chk("timeout_latency", (cyc - ref_cyc >= T) && (cyc - ref_cyc <= T + 2), 1);
        end
        @(negedge clk);
        chk("rsp_single_cycle", o_rsp_valid, 0);
        chk("ready_after_rsp", o_cmd_ready, 1);
        chk("rsp_data_hold", o_rsp_data, v.rsp);
        #1 chk("rsp_pulse_count", rsp_cnt - c0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        vec_t v;
        repeat (2) @(negedge clk);
        chk("rst_ready", o_cmd_ready, 1);
        chk("rst_tx_valid", o_tx_p_valid, 0);
        chk("rst_tx_data", o_tx_p_data, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_data", o_rsp_data, 0);
        chk("rst_rsp_timeout", o_rsp_timeout, 0);
        chk("rst_rx_drop", o_rx_drop, 0);
        i_arst_n = 1;

        //       cmd   addr  wd     a      b      fun   nrep r0     r1     mode late len tx            rsp       to
        vt[0] = mk(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0, 0, 3, 32'hAA053C00, 16'h0000, 0);
        vt[1] = mk(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h7E, 8'h00, 0, 0, 2, 32'hBB020000, 16'h007E, 0);
        vt[2] = mk(2'd2, 4'h0, 8'h00, 8'h10, 8'h03, 4'h0, 2, 8'h0D, 8'h00, 0, 0, 4, 32'hCC100300, 16'h000D, 0);
        vt[3] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 2, 8'h30, 8'h00, 1, 0, 2, 32'hDD020000, 16'h0030, 0);
        vt[4] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h7, 1, 8'h55, 8'h00, 0, 0, 2, 32'hDD070000, 16'h0055, 1);
        vt[5] = mk(2'd0, 4'hF, 8'hFF, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 2, 0, 3, 32'hAA0FFF00, 16'h0000, 0);
        vt[6] = mk(2'd2, 4'h0, 8'h00, 8'h01, 8'h02, 4'hF, 0, 8'h00, 8'h00, 1, 0, 4, 32'hCC01020F, 16'h0000, 1);
        vt[7] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1, 2, 8'hA5, 8'h5A, 0, 1, 2, 32'hDD010000, 16'h5AA5, 0);
        for (int i = 0; i < 8; i++) run_cmd(vt[i]);

        // rx byte while idle is discarded and flagged
        @(negedge clk);
        c0 = rsp_cnt;
        i_rx_d_valid = 1; i_rx_p_data = 8'h5A;
        @(negedge clk);
        i_rx_d_valid = 0;
        chk("rx_drop_pulse", o_rx_drop, 1);
        @(negedge clk);
        chk("rx_drop_clear", o_rx_drop, 0);
        chk("rx_drop_no_rsp", rsp_cnt - c0, 0);
        chk("rx_drop_ready", o_cmd_ready, 1);

        // async reset in the middle of a CC frame
        i_cmd_valid = 1; i_cmd_type = 2'd2; i_op_a = 8'h11; i_op_b = 8'h22; i_alu_fun = 4'h3;
        @(negedge clk);
        i_cmd_valid = 0; i_tx_ready = 1;
        @(negedge clk);
        i_tx_ready = 0;
        chk("mid_frame_byte", o_tx_p_data, 8'h11);
        c0 = rsp_cnt;
        i_arst_n = 0;
        #1;
        chk("arst_ready", o_cmd_ready, 1);
        chk("arst_tx_valid", o_tx_p_valid, 0);
        chk("arst_rsp_valid", o_rsp_valid, 0);
        chk("arst_rsp_data", o_rsp_data, 0);
        chk("arst_rsp_timeout", o_rsp_timeout, 0);
        @(negedge clk);
        i_arst_n = 1;
        repeat (3) @(negedge clk);
        chk("arst_no_resume", o_tx_p_valid, 0);
        chk("arst_no_rsp", rsp_cnt - c0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] cmd;
            int rl, nrep;
            cmd = 2'($urandom_range(0, 3));
            rl = (cmd == 0) ? 0 : (cmd == 1) ? 1 : 2;
            nrep = (rl > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, rl - 1) : rl;
            v = model(cmd, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                      nrep, 8'($urandom), 8'($urandom), $urandom_range(0, 2));
            run_cmd(v);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
